// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, byte-lane constants
// and elaboration-time helpers.
package dmem_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned WORD_W    = BYTE_W * NUM_LANES;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    function automatic logic [WORD_W-1:0] lane_bits(input logic [NUM_LANES-1:0] mask);
        logic [WORD_W-1:0] bits;
        bits = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            bits[i*BYTE_W +: BYTE_W] = {BYTE_W{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                            clk_i,
    input  logic                            we_i,
    input  logic [NUM_LANES-1:0]            be_i,
    input  logic [clog2(DEPTH_WORDS)-1:0]   addr_i,
    input  logic [WORD_W-1:0]               wdata_i,
    output logic [WORD_W-1:0]               rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we_i && be_i[i]) begin
                mem[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding dmem target. Define DMEM_ERR_EN to add the o_rsp_err
// output and suppress array writes for malformed requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
`ifdef DMEM_ERR_EN
    output logic        o_rsp_err,
`endif
    output logic [31:0] o_rsp_rdata
);

    localparam int unsigned IDX_W = clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 2) ? clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   wr_q, wr_d;
    logic [WORD_W-1:0]      wdata_q, wdata_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic                   req_accept;
    logic                   rsp_err;
    logic [WORD_W-1:0]      mem_rdata;

`ifdef DMEM_ERR_EN
    logic err_q, err_d;
    logic req_err;

    assign req_err = (i_req_ren & i_req_wen) | (i_req_addr[1:0] != 2'b00) |
                     (i_req_mask == '0) | ({32'd0, i_req_addr} >= (64'(DEPTH_WORDS) << 2));
    assign rsp_err   = err_q;
    assign o_rsp_err = (state_q == ST_RESP) & err_q;
`else
    logic unused_addr_bits;

    // Upper bits alias and the byte offset is don't-care without error checking.
    assign unused_addr_bits = ^{i_req_addr[31:IDX_W+2], i_req_addr[1:0]};
    assign rsp_err = 1'b0;
`endif

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign req_accept  = (i_req_ren | i_req_wen) & o_req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
`ifdef DMEM_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    idx_d   = i_req_addr[IDX_W+1:2];
                    // A simultaneous read+write is handled as a write.
                    wr_d    = i_req_wen;
                    wdata_d = i_req_wdata;
                    mask_d  = i_req_mask;
`ifdef DMEM_ERR_EN
                    err_d   = req_err;
`endif
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY >= 2) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
`ifdef DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
`ifdef DMEM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (i_clk),
        .we_i    ((state_q == ST_RESP) & wr_q & ~rsp_err),
        .be_i    (mask_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        o_rsp_rdata = '0;
        if ((state_q == ST_RESP) && !wr_q && !rsp_err) begin
            o_rsp_rdata = mem_rdata & lane_bits(mask_q);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 3 and 1; honours DMEM_ERR_EN.
module tb_dmem_responder;

`ifdef DMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ren, a_wen, a_ready, a_valid;
    logic [3:0]  a_mask;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ren, b_wen, b_ready, b_valid;
    logic [3:0]  b_mask;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_ren, c_wen, c_ready, c_valid;
    logic [3:0]  c_mask;
`ifdef DMEM_ERR_EN
    logic        a_err, b_err, c_err;
`else
    logic        exp_err_unused;
`endif

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_addr  (a_addr),
        .i_req_ren   (a_ren),
        .i_req_wen   (a_wen),
        .i_req_wdata (a_wdata),
        .i_req_mask  (a_mask),
        .o_req_ready (a_ready),
        .o_rsp_valid (a_valid),
`ifdef DMEM_ERR_EN
        .o_rsp_err   (a_err),
`endif
        .o_rsp_rdata (a_rdata)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u_dut_l3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_addr  (b_addr),
        .i_req_ren   (b_ren),
        .i_req_wen   (b_wen),
        .i_req_wdata (b_wdata),
        .i_req_mask  (b_mask),
        .o_req_ready (b_ready),
        .o_rsp_valid (b_valid),
`ifdef DMEM_ERR_EN
        .o_rsp_err   (b_err),
`endif
        .o_rsp_rdata (b_rdata)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut_l1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_addr  (c_addr),
        .i_req_ren   (c_ren),
        .i_req_wen   (c_wen),
        .i_req_wdata (c_wdata),
        .i_req_mask  (c_mask),
        .o_req_ready (c_ready),
        .o_rsp_valid (c_valid),
`ifdef DMEM_ERR_EN
        .o_rsp_err   (c_err),
`endif
        .o_rsp_rdata (c_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge with the LATENCY=2 instance idle.
    task automatic a_txn(input string tag, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic [31:0] exp_rdata,
                         input logic exp_err);
        check({tag, " ready@T"}, 32'(a_ready), 32'd1);
        a_ren = ren; a_wen = wen; a_addr = addr; a_wdata = wdata; a_mask = mask;
        @(negedge clk);
        a_ren = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0; a_mask = '0;
        check({tag, " ready@T+1"}, 32'(a_ready), 32'd0);
        check({tag, " valid@T+1"}, 32'(a_valid), 32'd0);
        @(negedge clk);
        check({tag, " valid@T+2"}, 32'(a_valid), 32'd1);
        check({tag, " rdata@T+2"}, a_rdata, exp_rdata);
`ifdef DMEM_ERR_EN
        check({tag, " err@T+2"}, 32'(a_err), 32'(exp_err));
`else
        exp_err_unused = exp_err;
`endif
        @(negedge clk);
        check({tag, " ready@T+3"}, 32'(a_ready), 32'd1);
        check({tag, " valid@T+3"}, 32'(a_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_addr = '0; a_wdata = '0; a_ren = 1'b0; a_wen = 1'b0; a_mask = '0;
        b_addr = '0; b_wdata = '0; b_ren = 1'b0; b_wen = 1'b0; b_mask = '0;
        c_addr = '0; c_wdata = '0; c_ren = 1'b0; c_wen = 1'b0; c_mask = '0;
        repeat (2) @(negedge clk);
        check("reset a ready", 32'(a_ready), 32'd1);
        check("reset a valid", 32'(a_valid), 32'd0);
        check("reset a rdata", a_rdata, 32'd0);
        check("reset b ready", 32'(b_ready), 32'd1);
        check("reset c valid", 32'(c_valid), 32'd0);
        rst_n = 1'b1;

        a_txn("wr 0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        a_txn("rd 0x10", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        a_txn("wr 0x20", 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        a_txn("wr 0x20 lane3", 1'b0, 1'b1, 32'h20, 32'hAA000000, 4'h8, 32'h0, 1'b0);
        a_txn("rd 0x20 full", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'hAA223344, 1'b0);
        a_txn("rd 0x20 low", 1'b1, 1'b0, 32'h20, 32'h0, 4'h3, 32'h00003344, 1'b0);
        a_txn("wr 0x0", 1'b0, 1'b1, 32'h0, 32'h00000055, 4'hF, 32'h0, 1'b0);
        a_txn("wr 0x1000", 1'b0, 1'b1, 32'h1000, 32'h00001234, 4'hF, 32'h0, ERR);
        a_txn("rd 0x0 alias", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF,
              ERR ? 32'h00000055 : 32'h00001234, 1'b0);
        a_txn("wr mask0", 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, ERR);
        a_txn("rd after mask0", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        a_txn("ren+wen", 1'b1, 1'b1, 32'h10, 32'h000000FF, 4'h1, 32'h0, ERR);
        a_txn("rd after ren+wen", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF,
              ERR ? 32'hDEADBEEF : 32'hDEADBEFF, 1'b0);

        // Reset one cycle after a write is accepted: it must vanish without a response.
        a_wen = 1'b1; a_addr = 32'h20; a_wdata = 32'hFFFFFFFF; a_mask = 4'hF;
        @(negedge clk);
        a_wen = 1'b0; a_addr = '0; a_wdata = '0; a_mask = '0;
        check("rst-mid accepted", 32'(a_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst-mid ready", 32'(a_ready), 32'd1);
        check("rst-mid valid", 32'(a_valid), 32'd0);
        @(negedge clk);
        check("rst-mid valid@T+2", 32'(a_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst-mid ready after", 32'(a_ready), 32'd1);
        check("rst-mid valid after", 32'(a_valid), 32'd0);
        a_txn("rd 0x20 after rst", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'hAA223344, 1'b0);

        // LATENCY=3 with read request held high.
        b_wen = 1'b1; b_addr = 32'h4; b_wdata = 32'hCAFEF00D; b_mask = 4'hF;
        @(negedge clk);
        b_wen = 1'b0; b_wdata = '0;
        repeat (2) @(negedge clk);
        check("b wr valid@T+3", 32'(b_valid), 32'd1);
        @(negedge clk);
        b_ren = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("b ready k=%0d", k), 32'(b_ready), 32'((k % 4) == 0));
            check($sformatf("b valid k=%0d", k), 32'(b_valid), 32'((k % 4) == 3));
            if ((k % 4) == 3) begin
                check($sformatf("b rdata k=%0d", k), b_rdata, 32'hCAFEF00D);
            end
            @(negedge clk);
        end
        b_ren = 1'b0;
        check("b ready after burst", 32'(b_ready), 32'd1);
        @(negedge clk);
        check("b no extra valid", 32'(b_valid), 32'd0);

        // LATENCY=1 back-to-back reads.
        c_wen = 1'b1; c_addr = 32'h8; c_wdata = 32'h0BADF00D; c_mask = 4'hF;
        @(negedge clk);
        c_wen = 1'b0; c_wdata = '0;
        check("c wr valid@T+1", 32'(c_valid), 32'd1);
        @(negedge clk);
        c_ren = 1'b1; c_mask = 4'hC;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("c ready k=%0d", k), 32'(c_ready), 32'((k % 2) == 0));
            check($sformatf("c valid k=%0d", k), 32'(c_valid), 32'((k % 2) == 1));
            if ((k % 2) == 1) begin
                check($sformatf("c rdata k=%0d", k), c_rdata, 32'h0BAD0000);
            end
            @(negedge clk);
        end
        c_ren = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the hart's dmem port: the target side of the aligned-address, byte-masked read/write protocol the core drives as initiator. It replaces the zero-latency combinational memory model with a fixed-latency, single-outstanding request/response slave. It sits between the hart's memory stage and the on-chip data SRAM.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4.
- LATENCY, 2, cycles from request acceptance to response; integer ≥ 1.

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_addr  in  32  byte address; the hart sends it word-aligned.
- i_req_ren  in  1  read request.
- i_req_wen  in  1  write request.
- i_req_wdata  in  32  write data, already placed in the correct byte lanes.
- i_req_mask  in  4  byte-lane enables; bit n covers bits [8n+7:8n].
- o_req_ready  out  1  high when a request can be accepted.
- o_rsp_valid  out  1  one-cycle pulse marking completion of a read or write.
- o_rsp_rdata  out  32  read data; valid only while o_rsp_valid is high.

## Operation
- Requests are accepted on a cycle where (i_req_ren | i_req_wen) & o_req_ready. On acceptance, the block latches addr, ren, wen, wdata and mask.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so addresses alias modulo 4·DEPTH_WORDS.
  - addr[1:0] is ignored.
- Only one request may be outstanding. Request inputs presented while o_req_ready is low are ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT on accept when LATENCY ≥ 2.
  - IDLE → RESP on accept when LATENCY = 1.
  - WAIT: a down-counter loads LATENCY−2 on entry and decrements each cycle. WAIT → RESP when the counter is 0.
  - RESP → IDLE unconditionally after one cycle.
- In RESP:
  - o_rsp_valid = 1.
  - Read: o_rsp_rdata = stored word with unmasked byte lanes forced to 0.
  - Write: masked bytes are committed at the end of the RESP cycle, and o_rsp_rdata = 0.
- mask = 0 on a write: no bytes change, but the response is still issued.
- ren & wen both high is illegal on the protocol. The block treats it as a write.
- Reset clears only the FSM, the counter and the outputs. Array contents are not reset.

## Timing
- Reset values: o_req_ready = 1, o_rsp_valid = 0, o_rsp_rdata = 0, state = IDLE.
- For a request accepted in cycle T:
  - o_req_ready is low from T+1 to T+LATENCY.
  - o_rsp_valid is high in cycle T+LATENCY only.
  - o_req_ready returns high in T+LATENCY+1.
- Sustained throughput is one request per LATENCY+1 cycles.
- Write visibility: a read accepted at or after T+LATENCY+1 observes the new bytes.
- o_req_ready depends only on state. There is no combinational path from the request inputs to any output.
- Reset asserted mid-request:
  - The in-flight request is dropped.
  - A pending write is not committed.
  - o_rsp_valid is never asserted for it.
  - Deassertion returns the block to IDLE with ready high on the next edge.

## Configuration
- DMEM_ERR_EN defined:
  - Adds output o_rsp_err (1 bit, reset 0), valid with o_rsp_valid.
  - err = 1 when any of these hold for the request: ren & wen, addr[1:0] ≠ 0, mask = 0, or addr ≥ 4·DEPTH_WORDS.
  - An erroring request never writes the array and returns rdata = 0.
- DMEM_ERR_EN undefined:
  - The o_rsp_err port is absent.
  - Aliasing and the write-priority rules above apply.

## Structure
- Shared package dmem_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP),
  - byte-lane constants,
  - the index-width function clog2(DEPTH_WORDS).
- One sub-module, dmem_array: synchronous-write, combinational-read, DEPTH_WORDS×32 storage with 4 byte write-enables.
- The top level contains the FSM, the latency counter, the request latches and the response muxing.

## Test plan
- Reset, then write addr 0x10, wdata 0xDEADBEEF, mask 0xF; then read 0x10, mask 0xF → rsp_valid at T+2 for each request; read rdata = 0xDEADBEEF.
- Write wdata 0xAA000000 with mask 0x8 to a word holding 0x11223344, then read with mask 0xF → 0xAA223344; a read with mask 0x3 → 0x00003344.
- Hold ren high continuously at LATENCY=3 → accepts at cycles 0, 4, 8; ready low on cycles 1–3; exactly one rsp_valid per accept.
- With DEPTH_WORDS=1024, write 0x1234 to 0x1000 and read 0x0000 → 0x1234 (aliasing); with DMEM_ERR_EN → err = 1 and rdata = 0 instead.
- Assert i_rst_n low one cycle after accepting a write to 0x20 → no rsp_valid; ready = 1 after release; a read of 0x20 returns the old contents.
- LATENCY=1: back-to-back reads → rsp_valid in T+1; next accept in T+2.
